cacheline_adapter: RTL



---
 rtl/cacheline_adapter_pkg.sv | 27 ++
 rtl/cacheline_adapter_if.sv | 34 +++
 rtl/cacheline_adapter.sv | 94 +++++++++
 3 files changed

// File: rtl/cacheline_adapter_pkg.sv
// Shared types and sizing for the cacheline adapter: line/beat geometry,
// FSM state encoding and the line-alignment helper.
package cacheline_adapter_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;
  localparam int ADDR_WIDTH  = 32;
  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } adapter_state_t;

  typedef logic [LINE_WIDTH-1:0]  cacheline_t;
  typedef logic [BURST_WIDTH-1:0] beat_t;
  typedef logic [ADDR_WIDTH-1:0]  addr_t;

  // Bursts always start at the first byte of the line.
  function automatic addr_t line_align(input addr_t addr);
    return {addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/cacheline_adapter_if.sv
// Bundles the arbiter-side line port and the memory-side burst port.
// The slave modport is the adapter's view; master is the environment's view.
interface cacheline_adapter_if;
  import cacheline_adapter_pkg::*;

  logic       line_read_i;
  logic       line_write_i;
  addr_t      line_addr_i;
  cacheline_t line_wdata_i;
  cacheline_t line_rdata_o;
  logic       line_resp_o;

  logic       burst_read_o;
  logic       burst_write_o;
  addr_t      burst_addr_o;
  beat_t      burst_wdata_o;
  beat_t      burst_rdata_i;
  logic       burst_resp_i;

  modport slave (
    input  line_read_i, line_write_i, line_addr_i, line_wdata_i,
    input  burst_rdata_i, burst_resp_i,
    output line_rdata_o, line_resp_o,
    output burst_read_o, burst_write_o, burst_addr_o, burst_wdata_o
  );

  modport master (
    output line_read_i, line_write_i, line_addr_i, line_wdata_i,
    output burst_rdata_i, burst_resp_i,
    input  line_rdata_o, line_resp_o,
    input  burst_read_o, burst_write_o, burst_addr_o, burst_wdata_o
  );

endinterface

// File: rtl/cacheline_adapter.sv
// Turns one 256-bit line read/write into a 4-beat 64-bit memory burst and
// returns a single-cycle completion pulse; every output is registered.
module cacheline_adapter
  import cacheline_adapter_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  cacheline_adapter_if.slave  bus
);

  adapter_state_t state, next_state;
  logic [1:0]     beat;
  cacheline_t     line_buf;
  logic           last_beat;

  assign last_beat = bus.burst_resp_i && (beat == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.line_write_i)     next_state = WRITE;
        else if (bus.line_read_i) next_state = READ;
      end
      READ:    if (last_beat) next_state = DONE;
      WRITE:   if (last_beat) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are set on the edge entering a state so they appear in that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat              <= 2'd0;
      line_buf          <= '0;
      bus.line_rdata_o  <= '0;
      bus.line_resp_o   <= 1'b0;
      bus.burst_read_o  <= 1'b0;
      bus.burst_write_o <= 1'b0;
      bus.burst_addr_o  <= '0;
      bus.burst_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.line_write_i) begin
            bus.burst_addr_o  <= line_align(bus.line_addr_i);
            line_buf          <= bus.line_wdata_i;
            bus.burst_wdata_o <= bus.line_wdata_i[BURST_WIDTH-1:0];
            bus.burst_write_o <= 1'b1;
          end else if (bus.line_read_i) begin
            bus.burst_addr_o  <= line_align(bus.line_addr_i);
            bus.burst_read_o  <= 1'b1;
          end
        end
        READ: begin
          if (bus.burst_resp_i) begin
            line_buf[int'(beat)*BURST_WIDTH +: BURST_WIDTH] <= bus.burst_rdata_i;
            beat <= beat + 2'd1;
            if (beat == 2'd3) begin
              bus.burst_read_o <= 1'b0;
              bus.line_resp_o  <= 1'b1;
              // The final beat bypasses the buffer so the line is complete in DONE.
              bus.line_rdata_o <= {bus.burst_rdata_i, line_buf[LINE_WIDTH-BURST_WIDTH-1:0]};
            end
          end
        end
        WRITE: begin
          if (bus.burst_resp_i) begin
            beat <= beat + 2'd1;
            if (beat == 2'd3) begin
              bus.burst_write_o <= 1'b0;
              bus.burst_wdata_o <= '0;
              bus.line_resp_o   <= 1'b1;
            end else begin
              bus.burst_wdata_o <= line_buf[(int'(beat) + 1)*BURST_WIDTH +: BURST_WIDTH];
            end
          end
        end
        DONE: begin
          bus.line_resp_o <= 1'b0;
          beat            <= 2'd0;
        end
        default: beat <= 2'd0;
      endcase
    end
  end

endmodule
